mult_rs: RTL and testbench
==========================

MULT_RS -- requirements
Module: mult_rs

Interface
REQ-001 Parameter ROB_IX, default 2; ROB tags are ROB_IX+1 bits wide.
REQ-002 Parameter ENTRIES, default 4; the number of reservation-station slots (at least 2).
REQ-003 clk_in  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_in  input  1  reset, asynchronous and active-high.
REQ-005 flush_in  input  1  synchronous squash of all entries.
REQ-006 dispatch_valid_in  input  1  dispatch request this cycle.
REQ-007 dispatch_ready_out  output  1  at least one free slot; combinational from registered state.
REQ-008 rob_ix_in  input  ROB_IX+1  destination ROB tag of the dispatched op.
REQ-009 src1_val_in, src2_val_in  input  32 each  operand values (signed), meaningful when the matching rdy bit is 1.
REQ-010 src1_rdy_in, src2_rdy_in  input  1 each  operand value is already available.
REQ-011 src1_tag_in, src2_tag_in  input  ROB_IX+1 each  producer ROB tag, meaningful when the matching rdy bit is 0.
REQ-012 cdb_valid_in  input  1  common data bus broadcast valid.
REQ-013 cdb_rob_ix_in  input  ROB_IX+1  tag of the broadcast result.
REQ-014 cdb_data_in  input  32  broadcast result value.
REQ-015 mult_ready_in  input  1  downstream multiplier is idle (its ready output).
REQ-016 mult_valid_out  output  1  registered one-cycle issue pulse to the multiplier.
REQ-017 mult_rval1_out, mult_rval2_out  output  32 each  issued operands, registered.
REQ-018 mult_rob_ix_out  output  ROB_IX+1  issued ROB tag, registered.
REQ-019 count_out  output  $clog2(ENTRIES)+1  number of busy slots.

Function
REQ-020 Each slot SHALL hold: busy, rob_ix, val1/rdy1/tag1, val2/rdy2/tag2.
REQ-021 dispatch_ready_out SHALL be 1 exactly when count_out < ENTRIES; a slot freed by issue in the same cycle does not count until the next cycle.
REQ-022 Dispatch is accepted when dispatch_valid_in & dispatch_ready_out & !flush_in. The op is written into the lowest-index non-busy slot, with busy=1.
REQ-023 Dispatch with dispatch_ready_out=0 SHALL be ignored and leave no state change.
REQ-024 Wakeup: when cdb_valid_in=1, every busy slot operand with rdy=0 and tag==cdb_rob_ix_in SHALL take val=cdb_data_in and rdy=1. Operands with rdy=1 are unaffected.
REQ-025 Same-cycle forwarding: a dispatched operand with rdy_in=0 and tag_in matching a valid CDB broadcast SHALL be written with rdy=1 and the CDB value.
REQ-026 A slot is issuable when busy & rdy1 & rdy2, using registered state only. An operand woken this cycle makes the slot issuable from the next cycle.
REQ-027 Issue occurs at an edge where mult_ready_in=1, mult_valid_out=0, flush_in=0 and at least one slot is issuable. The lowest-index issuable slot is selected.
REQ-028 On issue, the selected slot's val1, val2 and rob_ix SHALL be registered onto the mult outputs. mult_valid_out=1 for exactly the next cycle, and the slot's busy is cleared on that same edge.
REQ-029 mult_valid_out SHALL never be high in two consecutive cycles. This covers the one-cycle lag before the multiplier drops its ready signal.
REQ-030 When no issue occurs, mult_valid_out SHALL be 0. The data outputs hold their last values.
REQ-031 Simultaneous dispatch and issue SHALL leave count_out unchanged. Dispatch may not target the slot being issued in that cycle.
REQ-032 flush_in=1 SHALL clear every busy bit, force mult_valid_out=0 on the next cycle, and block both dispatch and issue for that cycle.
REQ-033 count_out SHALL equal the population count of the busy bits, updated each edge.

Reset
REQ-034 While rst_in=1, the block SHALL immediately clear all busy, rdy, val, tag and rob_ix fields, set mult_valid_out=0, set mult_rval1_out=mult_rval2_out=0 and mult_rob_ix_out=0.
REQ-035 On reset, count_out=0 and dispatch_ready_out=1. Reset asserted mid-operation discards all pending ops without issuing them.

Verification
REQ-036 Ready dispatch: dispatch rob 3, src1=7, src2=-6, both rdy, mult_ready_in=1 -> next cycle mult_valid_out=1, rval1=7, rval2=-6, rob_ix=3, count_out=0.
REQ-037 Wakeup: dispatch rob 1 with src1 tag 5 not ready, src2=4; CDB tag 5 data 9 two cycles later -> issue of (9,4,rob 1) one cycle after the broadcast cycle, not before.
REQ-038 Same-cycle forward: dispatch src2 tag 2 with CDB tag 2 data 0x100 in the same cycle -> entry issues the next cycle with rval2=0x100.
REQ-039 Full/backpressure: mult_ready_in=0, dispatch 4 ready ops (ENTRIES=4) -> count_out=4, dispatch_ready_out=0, a 5th dispatch is ignored. Raising mult_ready_in issues slot 0 first, with pulses at least 2 cycles apart.
REQ-040 Flush: 3 busy entries, flush_in=1 together with dispatch_valid_in=1 -> count_out=0 next cycle, no mult_valid_out pulse, the dispatch is dropped.
REQ-041 Async reset: assert rst_in between clock edges while 2 entries are busy -> count_out=0 and mult_valid_out=0 immediately, with no issue after release.

Source files
------------

// File: rtl/mult_rs.sv
// Reservation station for the multiplier: holds dispatched ops, snoops the
// CDB for missing operands and issues ready ops one at a time.
module mult_rs #(
  parameter int ROB_IX  = 2,
  parameter int ENTRIES = 4
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      flush_in,
  input  logic                      dispatch_valid_in,
  output logic                      dispatch_ready_out,
  input  logic [ROB_IX:0]           rob_ix_in,
  input  logic [31:0]               src1_val_in,
  input  logic [31:0]               src2_val_in,
  input  logic                      src1_rdy_in,
  input  logic                      src2_rdy_in,
  input  logic [ROB_IX:0]           src1_tag_in,
  input  logic [ROB_IX:0]           src2_tag_in,
  input  logic                      cdb_valid_in,
  input  logic [ROB_IX:0]           cdb_rob_ix_in,
  input  logic [31:0]               cdb_data_in,
  input  logic                      mult_ready_in,
  output logic                      mult_valid_out,
  output logic [31:0]               mult_rval1_out,
  output logic [31:0]               mult_rval2_out,
  output logic [ROB_IX:0]           mult_rob_ix_out,
  output logic [$clog2(ENTRIES):0]  count_out
);

  localparam int TW = ROB_IX + 1;
  localparam int SW = $clog2(ENTRIES);
  localparam int CW = SW + 1;

  logic [ENTRIES-1:0] busy;
  logic [ENTRIES-1:0] rdy1;
  logic [ENTRIES-1:0] rdy2;
  logic [TW-1:0]      rob   [ENTRIES];
  logic [TW-1:0]      tag1  [ENTRIES];
  logic [TW-1:0]      tag2  [ENTRIES];
  logic [31:0]        val1  [ENTRIES];
  logic [31:0]        val2  [ENTRIES];

  logic          free_hit;
  logic [SW-1:0] free_ix;
  logic          iss_hit;
  logic [SW-1:0] iss_ix;
  logic [CW-1:0] cnt;
  logic          do_disp;
  logic          do_iss;
  logic          d_rdy1;
  logic          d_rdy2;
  logic [31:0]   d_val1;
  logic [31:0]   d_val2;

  // Occupancy count and lowest-index free / issuable slot selection.
  always_comb begin
    cnt      = '0;
    free_hit = 1'b0;
    free_ix  = '0;
    iss_hit  = 1'b0;
    iss_ix   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      cnt = cnt + {{(CW-1){1'b0}}, busy[i]};
      if (!busy[i]) begin
        free_hit = 1'b1;
        free_ix  = SW'(i);
      end
      if (busy[i] && rdy1[i] && rdy2[i]) begin
        iss_hit = 1'b1;
        iss_ix  = SW'(i);
      end
    end
  end

  assign count_out          = cnt;
  assign dispatch_ready_out = free_hit;

  assign do_disp = dispatch_valid_in & dispatch_ready_out & ~flush_in;
  // The pulse itself blocks the next issue, covering the multiplier's
  // one-cycle lag in dropping its ready.
  assign do_iss  = mult_ready_in & ~mult_valid_out & ~flush_in & iss_hit;

  // Operands still pending at dispatch can be caught off this cycle's CDB.
  assign d_rdy1 = src1_rdy_in |
                  (cdb_valid_in && cdb_rob_ix_in == src1_tag_in);
  assign d_rdy2 = src2_rdy_in |
                  (cdb_valid_in && cdb_rob_ix_in == src2_tag_in);
  assign d_val1 = src1_rdy_in ? src1_val_in : cdb_data_in;
  assign d_val2 = src2_rdy_in ? src2_val_in : cdb_data_in;

  // Slot array: flush, issue release, CDB wakeup and dispatch write.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy <= '0;
      rdy1 <= '0;
      rdy2 <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        rob[i]  <= '0;
        tag1[i] <= '0;
        tag2[i] <= '0;
        val1[i] <= '0;
        val2[i] <= '0;
      end
    end else if (flush_in) begin
      busy <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (do_iss && iss_ix == SW'(i)) begin
          busy[i] <= 1'b0;
        end
        if (busy[i] && cdb_valid_in) begin
          if (!rdy1[i] && tag1[i] == cdb_rob_ix_in) begin
            rdy1[i] <= 1'b1;
            val1[i] <= cdb_data_in;
          end
          if (!rdy2[i] && tag2[i] == cdb_rob_ix_in) begin
            rdy2[i] <= 1'b1;
            val2[i] <= cdb_data_in;
          end
        end
        if (do_disp && free_ix == SW'(i)) begin
          busy[i] <= 1'b1;
          rob[i]  <= rob_ix_in;
          rdy1[i] <= d_rdy1;
          rdy2[i] <= d_rdy2;
          tag1[i] <= src1_tag_in;
          tag2[i] <= src2_tag_in;
          val1[i] <= d_val1;
          val2[i] <= d_val2;
        end
      end
    end
  end

  // Issue register towards the multiplier; data holds between pulses.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mult_valid_out  <= 1'b0;
      mult_rval1_out  <= '0;
      mult_rval2_out  <= '0;
      mult_rob_ix_out <= '0;
    end else begin
      mult_valid_out <= do_iss;
      if (do_iss) begin
        mult_rval1_out  <= val1[iss_ix];
        mult_rval2_out  <= val2[iss_ix];
        mult_rob_ix_out <= rob[iss_ix];
      end
    end
  end

endmodule

// File: tb/tb_mult_rs.sv
// Directed bench for mult_rs: dispatch, wakeup, forwarding,
// backpressure, flush and asynchronous reset.
module tb_mult_rs;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        dv;
  logic        dr;
  logic [2:0]  rob;
  logic [31:0] v1, v2;
  logic        r1, r2;
  logic [2:0]  t1, t2;
  logic        cv;
  logic [2:0]  ctag;
  logic [31:0] cdata;
  logic        mrdy;
  logic        mv;
  logic [31:0] mr1, mr2;
  logic [2:0]  mrob;
  logic [2:0]  cnt;

  int total = 0;
  int bad   = 0;

  mult_rs #(.ROB_IX(2), .ENTRIES(4)) dut (
    .clk_in(clk), .rst_in(rst), .flush_in(flush),
    .dispatch_valid_in(dv), .dispatch_ready_out(dr),
    .rob_ix_in(rob),
    .src1_val_in(v1), .src2_val_in(v2),
    .src1_rdy_in(r1), .src2_rdy_in(r2),
    .src1_tag_in(t1), .src2_tag_in(t2),
    .cdb_valid_in(cv), .cdb_rob_ix_in(ctag), .cdb_data_in(cdata),
    .mult_ready_in(mrdy), .mult_valid_out(mv),
    .mult_rval1_out(mr1), .mult_rval2_out(mr2),
    .mult_rob_ix_out(mrob), .count_out(cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [2:0] rb,
                      input logic [31:0] a, input logic ra,
                      input logic [2:0] ta,
                      input logic [31:0] b, input logic rb2,
                      input logic [2:0] tb);
    dv = 1'b1; rob = rb;
    v1 = a; r1 = ra; t1 = ta;
    v2 = b; r2 = rb2; t2 = tb;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; dv = 1'b0; rob = '0;
    v1 = '0; v2 = '0; r1 = 1'b0; r2 = 1'b0; t1 = '0; t2 = '0;
    cv = 1'b0; ctag = '0; cdata = '0; mrdy = 1'b0;
    #12;
    chk("rst_cnt", 32'(cnt), 0);
    chk("rst_rdy", 32'(dr), 1);
    chk("rst_mv", 32'(mv), 0);
    chk("rst_r1", mr1, 0);
    chk("rst_rob", 32'(mrob), 0);
    rst = 1'b0;
    tick();

    // ready dispatch
    mrdy = 1'b1;
    disp(3'd3, 32'd7, 1'b1, 3'd0, 32'hFFFF_FFFA, 1'b1, 3'd0);
    tick();
    dv = 1'b0;
    chk("rd_mv0", 32'(mv), 0);
    chk("rd_cnt1", 32'(cnt), 1);
    tick();
    chk("rd_mv", 32'(mv), 1);
    chk("rd_v1", mr1, 7);
    chk("rd_v2", mr2, 32'hFFFF_FFFA);
    chk("rd_rob", 32'(mrob), 3);
    chk("rd_cnt", 32'(cnt), 0);
    tick();
    chk("rd_mv_off", 32'(mv), 0);

    // wakeup
    disp(3'd1, 32'd0, 1'b0, 3'd5, 32'd4, 1'b1, 3'd0);
    tick();
    dv = 1'b0;
    tick();
    chk("wk_mv_e2", 32'(mv), 0);
    cv = 1'b1; ctag = 3'd5; cdata = 32'd9;
    tick();
    cv = 1'b0;
    chk("wk_mv_e3", 32'(mv), 0);
    tick();
    chk("wk_mv", 32'(mv), 1);
    chk("wk_v1", mr1, 9);
    chk("wk_v2", mr2, 4);
    chk("wk_rob", 32'(mrob), 1);

    // same-cycle forward
    disp(3'd0, 32'd3, 1'b1, 3'd0, 32'd0, 1'b0, 3'd2);
    cv = 1'b1; ctag = 3'd2; cdata = 32'h100;
    tick();
    dv = 1'b0; cv = 1'b0;
    chk("fw_mv0", 32'(mv), 0);
    tick();
    chk("fw_mv", 32'(mv), 1);
    chk("fw_v1", mr1, 3);
    chk("fw_v2", mr2, 32'h100);
    chk("fw_rob", 32'(mrob), 0);
    tick();

    // full / backpressure
    mrdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      disp(3'(4 + i), 32'(i + 1), 1'b1, 3'd0, 32'(10 * (i + 1)), 1'b1, 3'd0);
      tick();
    end
    chk("fl_cnt4", 32'(cnt), 4);
    chk("fl_rdy0", 32'(dr), 0);
    disp(3'd0, 32'd99, 1'b1, 3'd0, 32'd99, 1'b1, 3'd0);
    tick();
    dv = 1'b0;
    chk("fl_cnt_5th", 32'(cnt), 4);
    chk("fl_mv_hold", 32'(mv), 0);
    mrdy = 1'b1;
    tick();
    chk("fl_mv1", 32'(mv), 1);
    chk("fl_rob1", 32'(mrob), 4);
    chk("fl_v1a", mr1, 1);
    chk("fl_v2a", mr2, 10);
    tick();
    chk("fl_gap", 32'(mv), 0);
    chk("fl_cnt3", 32'(cnt), 3);
    tick();
    chk("fl_mv2", 32'(mv), 1);
    chk("fl_rob2", 32'(mrob), 5);
    chk("fl_cnt2", 32'(cnt), 2);
    tick();
    tick();
    chk("fl_rob3", 32'(mrob), 6);
    tick();
    tick();
    chk("fl_mv4", 32'(mv), 1);
    chk("fl_rob4", 32'(mrob), 7);
    chk("fl_v1d", mr1, 4);
    tick();
    tick();
    chk("fl_drop_mv", 32'(mv), 0);
    chk("fl_drop_cnt", 32'(cnt), 0);

    // flush
    mrdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      disp(3'(i), 32'd5, 1'b1, 3'd0, 32'd6, 1'b1, 3'd0);
      tick();
    end
    chk("fs_cnt3", 32'(cnt), 3);
    disp(3'd7, 32'd1, 1'b1, 3'd0, 32'd1, 1'b1, 3'd0);
    flush = 1'b1; mrdy = 1'b1;
    tick();
    flush = 1'b0; dv = 1'b0;
    chk("fs_cnt0", 32'(cnt), 0);
    chk("fs_mv0", 32'(mv), 0);
    tick();
    chk("fs_mv1", 32'(mv), 0);
    tick();
    chk("fs_mv2", 32'(mv), 0);
    chk("fs_cnt_end", 32'(cnt), 0);

    // async reset mid-operation
    mrdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      disp(3'(i + 1), 32'd11, 1'b1, 3'd0, 32'd12, 1'b1, 3'd0);
      tick();
    end
    dv = 1'b0;
    mrdy = 1'b1;
    tick();
    chk("ar_mv_pre", 32'(mv), 1);
    chk("ar_cnt_pre", 32'(cnt), 2);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_cnt", 32'(cnt), 0);
    chk("ar_mv", 32'(mv), 0);
    chk("ar_v1", mr1, 0);
    chk("ar_rdy", 32'(dr), 1);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ar_no_iss", 32'(mv), 0);
    end
    chk("ar_cnt_end", 32'(cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
